// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with frame-synchronous
// shadowing of the displayed symbols and a free-running per-digit blink.
module ssd_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] ssd,
    input  logic [3:0]  blink_en,
    output logic [3:0]  active_digit,
    output logic [6:0]  seven_out,
    output logic        frame_tick
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    localparam logic [4:0]  SYM_BLANK    = 5'd21;
    localparam logic [19:0] SHADOW_RESET = {4{SYM_BLANK}};
    localparam logic [6:0]  SEG_OFF      = 7'h7F;

    // Active-low cathode pattern {g,f,e,d,c,b,a} for every 5-bit symbol.
    function automatic logic [6:0] seg_decode(input logic [4:0] sym);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (sym)
            5'd0:    seg = 7'h40;
            5'd1:    seg = 7'h79;
            5'd2:    seg = 7'h24;
            5'd3:    seg = 7'h30;
            5'd4:    seg = 7'h19;
            5'd5:    seg = 7'h12;
            5'd6:    seg = 7'h02;
            5'd7:    seg = 7'h78;
            5'd8:    seg = 7'h00;
            5'd9:    seg = 7'h10;
            5'd10:   seg = 7'h08;
            5'd11:   seg = 7'h03;
            5'd12:   seg = 7'h46;
            5'd13:   seg = 7'h21;
            5'd14:   seg = 7'h06;
            5'd15:   seg = 7'h0E;
            5'd16:   seg = 7'h47;
            5'd17:   seg = 7'h21;
            5'd18:   seg = 7'h0C;
            5'd19:   seg = 7'h2B;
            5'd20:   seg = 7'h3F;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [BW-1:0] blink_cnt_q,   blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [1:0]    index_q,       index_d;
    logic [19:0]   shadow_ssd_q,  shadow_ssd_d;
    logic [3:0]    shadow_blink_q, shadow_blink_d;
    logic [3:0]    active_digit_q, active_digit_d;
    logic [6:0]    seven_q,       seven_d;
    logic          frame_tick_q,  frame_tick_d;

    logic          refresh_wrap;
    logic          blink_wrap;
    logic          frame_edge;
    logic [4:0]    shadow_sym [4];
    logic [3:0]    anode_sel_n;
    logic [4:0]    cur_sym;
    logic          cur_blanked;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign shadow_sym[gi]  = shadow_ssd_q[gi*5 +: 5];
            assign anode_sel_n[gi] = (index_q != 2'(gi));
        end
    endgenerate

    assign cur_sym     = shadow_sym[index_q];
    assign cur_blanked = blink_phase_q & shadow_blink_q[index_q];

    always_comb begin
        refresh_cnt_d  = refresh_cnt_q;
        blink_cnt_d    = blink_cnt_q;
        blink_phase_d  = blink_phase_q;
        index_d        = index_q;
        shadow_ssd_d   = shadow_ssd_q;
        shadow_blink_d = shadow_blink_q;

        refresh_wrap = (refresh_cnt_q == REFRESH_LAST);
        blink_wrap   = (blink_cnt_q == BLINK_LAST);
        frame_edge   = refresh_wrap && (index_q == 2'd0);

        if (refresh_wrap) begin
            refresh_cnt_d = '0;
            index_d       = index_q - 2'd1;
        end else begin
            refresh_cnt_d = refresh_cnt_q + RW'(1);
        end

        // Blink timebase is deliberately unrelated to the scan position.
        if (blink_wrap) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end

        // Inputs are captured only here so a frame never shows a torn update.
        if (frame_edge) begin
            shadow_ssd_d   = ssd;
            shadow_blink_d = blink_en;
        end

        frame_tick_d   = frame_edge;
        active_digit_d = anode_sel_n;
        seven_d        = cur_blanked ? SEG_OFF : seg_decode(cur_sym);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt_q  <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            index_q        <= 2'd3;
            shadow_ssd_q   <= SHADOW_RESET;
            shadow_blink_q <= 4'b0000;
            active_digit_q <= 4'b1111;
            seven_q        <= SEG_OFF;
            frame_tick_q   <= 1'b0;
        end else begin
            refresh_cnt_q  <= refresh_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            index_q        <= index_d;
            shadow_ssd_q   <= shadow_ssd_d;
            shadow_blink_q <= shadow_blink_d;
            active_digit_q <= active_digit_d;
            seven_q        <= seven_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign active_digit = active_digit_q;
    assign seven_out    = seven_q;
    assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver with REFRESH_DIV=4 and BLINK_DIV=16.
module tb_ssd_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] ssd = 20'h00000;
    logic [3:0]  blink_en = 4'b0000;
    logic [3:0]  active_digit;
    logic [6:0]  seven_out;
    logic        frame_tick;

    ssd_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ssd          (ssd),
        .blink_en     (blink_en),
        .active_digit (active_digit),
        .seven_out    (seven_out),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       tick;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          n = 0;
    int          ticks = 0;
    logic [19:0] shadow_m;
    logic [3:0]  blink_m;
    logic [6:0]  dec_tab [32];

    localparam logic [19:0] BLANK4 = {4{5'd21}};
    localparam logic [19:0] CLSD   = {5'd12, 5'd16, 5'd5, 5'd17};
    localparam logic [19:0] OPEN   = {5'd0, 5'd18, 5'd14, 5'd19};
    localparam logic [19:0] DASH4  = {4{5'd20}};
    localparam logic [19:0] BLNKP  = {5'd5, 5'd1, 5'd2, 5'd31};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock: push the model's prediction, then compare on the falling edge.
    task automatic step();
        exp_t e;
        int   t, idx;
        logic [4:0] sym;
        @(posedge clk);
        if (!rst) begin
            e = '{an: 4'hF, seg: 7'h7F, tick: 1'b0};
            n = 0;
            shadow_m = BLANK4;
            blink_m = 4'b0000;
        end else begin
            n++;
            t = n - 1;
            idx = 3 - ((t / 4) % 4);
            sym = shadow_m[idx*5 +: 5];
            e.an = 4'hF;
            e.an[idx] = 1'b0;
            e.seg = ((((t / 16) % 2) == 1) && blink_m[idx]) ? 7'h7F : dec_tab[sym];
            e.tick = (n % 16 == 0);
            if (n % 16 == 0) begin
                shadow_m = ssd;
                blink_m = blink_en;
            end
        end
        sb_q.push_back(e);
        @(negedge clk);
        if (frame_tick) ticks++;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            $display("n=%0d anode=%b seg=%h tick=%b", n, active_digit, seven_out, frame_tick);
            check_eq($sformatf("anode@%0d", n), {28'd0, active_digit}, {28'd0, e.an});
            check_eq($sformatf("seg@%0d", n), {25'd0, seven_out}, {25'd0, e.seg});
            check_eq($sformatf("tick@%0d", n), {31'd0, frame_tick}, {31'd0, e.tick});
        end
    endtask

    initial begin
        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                    7'h47, 7'h21, 7'h0C, 7'h2B, 7'h3F, 7'h7F, 7'h7F, 7'h7F,
                    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        shadow_m = BLANK4;
        blink_m = 4'b0000;
        ssd = 20'hFFFFF;
        blink_en = 4'hF;

        for (int k = 0; k < 3; k++) step();

        // Scan order, no tearing, blink and illegal symbols in one long run.
        ssd = CLSD;
        blink_en = 4'b0000;
        rst = 1'b1;
        ticks = 0;
        for (int k = 0; k < 176; k++) begin
            step();
            if (n == 48) check_eq("ticks_48", ticks, 3);
            case (n)
                50: ssd = OPEN;
                69: ssd = DASH4;
                100: begin
                    ssd = BLNKP;
                    blink_en = 4'b1000;
                end
                default: ;
            endcase
        end

        // Mid-frame asynchronous reset.
        rst = 1'b0;
        for (int k = 0; k < 2; k++) step();
        rst = 1'b1;
        for (int k = 0; k < 7; k++) step();
        #1 rst = 1'b0;
        #1;
        check_eq("async_anode", {28'd0, active_digit}, 32'hF);
        check_eq("async_seg", {25'd0, seven_out}, 32'h7F);
        check_eq("async_tick", {31'd0, frame_tick}, 32'h0);
        for (int k = 0; k < 2; k++) step();
        rst = 1'b1;
        for (int k = 0; k < 40; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
